eccop_csr: RTL and testbench



---
 rtl/eccop_csr_pkg.sv | 25 ++
 rtl/eccop_csr_if.sv | 23 ++
 rtl/eccop_csr.sv | 178 +++++++++++++++++
 tb/tb_eccop_csr.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eccop_csr_pkg.sv
// Shared constants and types for the ECC coprocessor control/status register block.
package eccop_csr_pkg;

  localparam logic [13:0] REG_CTRL     = 14'd0;
  localparam logic [13:0] REG_STATUS   = 14'd1;
  localparam logic [13:0] REG_PC_START = 14'd2;
  localparam logic [13:0] REG_CYCLES   = 14'd3;
  localparam logic [13:0] REG_ID       = 14'd4;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_ABORT_BIT  = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 8;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned STATUS_ERR_BIT  = 2;
  localparam int unsigned STATUS_CODE_LSB = 8;

  localparam int unsigned PC_W = 14;

  localparam logic [7:0] ERR_ABORT = 8'hFF;

  typedef enum logic [1:0] {IDLE, RUN, ABORT} csr_state_t;

endpackage

// File: rtl/eccop_csr_if.sv
// Avalon-MM control port between the coprocessor interconnect and the CSR slave.
interface eccop_csr_if #(
  parameter int unsigned aw = 32,
  parameter int unsigned dw = 4
);
  logic [aw-1:0]   cmd_address;
  logic [dw-1:0]   cmd_byteenable;
  logic [8*dw-1:0] cmd_writedata;
  logic            cmd_write;
  logic            cmd_read;
  logic [8*dw-1:0] cmd_readdata;
  logic            cmd_waitrequest;

  modport master (
    output cmd_address, cmd_byteenable, cmd_writedata, cmd_write, cmd_read,
    input  cmd_readdata, cmd_waitrequest
  );

  modport slave (
    input  cmd_address, cmd_byteenable, cmd_writedata, cmd_write, cmd_read,
    output cmd_readdata, cmd_waitrequest
  );
endinterface

// File: rtl/eccop_csr.sv
// Control/status registers for the ECC coprocessor: entry PC, start/abort handshake to the
// command sequencer, status flags, cycle counter and level interrupt.
module eccop_csr
  import eccop_csr_pkg::*;
#(
  parameter int unsigned aw       = 32,
  parameter int unsigned dw       = 4,
  parameter logic [31:0] ID_VALUE = 32'hECC0_0100
) (
  input  logic             clk,
  input  logic             sreset,
  eccop_csr_if.slave       cmd,
  output logic             seq_start,
  output logic             seq_abort,
  output logic [PC_W-1:0]  seq_pc,
  input  logic             seq_busy,
  input  logic             seq_done,
  input  logic             seq_err,
  input  logic [7:0]       seq_err_code,
  output logic             irq
);

  logic [aw-1:0]   addr;
  logic [13:0]     idx;
  logic [dw-1:0]   be;
  logic [8*dw-1:0] wd;
  logic            unused_bits;

  assign addr        = cmd.cmd_address;
  assign idx         = addr[13:0];
  assign be          = cmd.cmd_byteenable;
  assign wd          = cmd.cmd_writedata;
  assign unused_bits = ^{addr[aw-1:14], be, wd};

  csr_state_t      state_q, state_d;
  logic            irq_en_q, irq_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      err_code_q, err_code_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     cycles_q, cycles_d, cycles_inc;
  logic            seq_start_q, seq_start_d;
  logic            seq_abort_q, seq_abort_d;
  logic            irq_q, irq_d;
  logic [8*dw-1:0] rdata_q, rdata_d, rd_mux;
  logic            rd_ack_q, rd_ack_d;

  logic wr_ctrl, wr_status, wr_pc, start_req, abort_req, busy;

  assign wr_ctrl   = cmd.cmd_write && (idx == REG_CTRL);
  assign wr_status = cmd.cmd_write && (idx == REG_STATUS);
  assign wr_pc     = cmd.cmd_write && (idx == REG_PC_START);
  assign start_req = wr_ctrl && be[0] && wd[CTRL_START_BIT];
  assign abort_req = wr_ctrl && be[0] && wd[CTRL_ABORT_BIT];
  assign busy      = (state_q != IDLE);
  assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    pc_d        = pc_q;
    cycles_d    = cycles_q;
    seq_start_d = 1'b0;
    seq_abort_d = 1'b0;

    if (wr_ctrl && be[1]) irq_en_d = wd[CTRL_IRQ_EN_BIT];
    if (wr_pc && !busy) begin
      if (be[0]) pc_d[7:0]  = wd[7:0];
      if (be[1]) pc_d[13:8] = wd[13:8];
    end
    // W1C is applied first so a hardware set in the same cycle overrides it.
    if (wr_status && be[0]) begin
      if (wd[STATUS_DONE_BIT]) done_d = 1'b0;
      if (wd[STATUS_ERR_BIT])  err_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          seq_start_d = 1'b1;
          cycles_d    = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        cycles_d = cycles_inc;
        // A sequencer completion in the same cycle as an abort write wins: the run is over.
        if (seq_done || seq_err) begin
          if (seq_done) done_d = 1'b1;
          if (seq_err) begin
            err_d      = 1'b1;
            err_code_d = seq_err_code;
          end
          state_d = IDLE;
        end else if (abort_req) begin
          seq_abort_d = 1'b1;
          state_d     = ABORT;
        end
      end
      ABORT: begin
        cycles_d = cycles_inc;
        if (!seq_busy) begin
          err_d      = 1'b1;
          err_code_d = ERR_ABORT;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_CTRL:     rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
      REG_STATUS: begin
        rd_mux[STATUS_BUSY_BIT]                    = busy;
        rd_mux[STATUS_DONE_BIT]                    = done_q;
        rd_mux[STATUS_ERR_BIT]                     = err_q;
        rd_mux[STATUS_CODE_LSB +: 8]               = err_code_q;
      end
      REG_PC_START: rd_mux[PC_W-1:0] = pc_q;
      REG_CYCLES:   rd_mux[31:0]     = cycles_q;
      REG_ID:       rd_mux[31:0]     = ID_VALUE;
      default:      rd_mux = '0;
    endcase
  end

  // One wait state: capture on the first read cycle, acknowledge on the second.
  always_comb begin
    rd_ack_d = cmd.cmd_read && !rd_ack_q;
    rdata_d  = rd_ack_d ? rd_mux : rdata_q;
    irq_d    = irq_en_q && (done_q || err_q);
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q     <= IDLE;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      pc_q        <= '0;
      cycles_q    <= '0;
      seq_start_q <= 1'b0;
      seq_abort_q <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
      rd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pc_q        <= pc_d;
      cycles_q    <= cycles_d;
      seq_start_q <= seq_start_d;
      seq_abort_q <= seq_abort_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
      rd_ack_q    <= rd_ack_d;
    end
  end

  assign cmd.cmd_waitrequest = cmd.cmd_read && !rd_ack_q;
  assign cmd.cmd_readdata    = rdata_q;
  assign seq_start           = seq_start_q;
  assign seq_abort           = seq_abort_q;
  assign seq_pc              = pc_q;
  assign irq                 = irq_q;

endmodule

// File: tb/tb_eccop_csr.sv
// Bench for eccop_csr: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a behavioural register-map model.
module tb_eccop_csr;

  logic        clk = 1'b0;
  logic        sreset;
  logic        seq_start, seq_abort, seq_busy, seq_done, seq_err, irq;
  logic [13:0] seq_pc;
  logic [7:0]  seq_err_code;

  always #5 clk = ~clk;

  eccop_csr_if #(.aw(32), .dw(4)) bus ();

  eccop_csr #(.aw(32), .dw(4), .ID_VALUE(32'hECC0_0100)) dut (
    .clk          (clk),
    .sreset       (sreset),
    .cmd          (bus.slave),
    .seq_start    (seq_start),
    .seq_abort    (seq_abort),
    .seq_pc       (seq_pc),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .seq_err_code (seq_err_code),
    .irq          (irq)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: mode 0 = idle, 1 = running, 2 = waiting for sequencer to stop.
  bit              m_valid = 0;
  int              m_mode;
  bit              m_irq_en, m_done, m_err, m_start, m_abort, m_irq, m_rd_ack;
  logic [7:0]      m_code;
  logic [13:0]     m_pc;
  longint unsigned m_cycles;
  logic [31:0]     m_rdata;

  function automatic logic [31:0] m_reg(int idx);
    case (idx)
      0: return {23'b0, m_irq_en, 8'b0};
      1: return {16'b0, m_code, 5'b0, m_err, m_done, (m_mode != 0)};
      2: return {18'b0, m_pc};
      3: return m_cycles[31:0];
      4: return 32'hECC0_0100;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    int          idx;
    logic [3:0]  be;
    logic [31:0] wd, rv;
    bit          wr, start_w, abort_w, busy_old, n_irq;
    if (sreset) begin
      m_valid = 1; m_mode = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_start = 0;
      m_abort = 0; m_irq = 0; m_rd_ack = 0; m_code = 0; m_pc = 0; m_cycles = 0; m_rdata = 0;
      return;
    end
    if (!m_valid) return;
    idx      = int'(bus.cmd_address[13:0]);
    be       = bus.cmd_byteenable;
    wd       = bus.cmd_writedata;
    wr       = bus.cmd_write;
    rv       = m_reg(idx);
    busy_old = (m_mode != 0);
    n_irq    = m_irq_en && (m_done || m_err);
    start_w  = wr && idx == 0 && be[0] && wd[0];
    abort_w  = wr && idx == 0 && be[0] && wd[1];
    if (bus.cmd_read && !m_rd_ack) begin
      m_rdata  = rv;
      m_rd_ack = 1;
    end else begin
      m_rd_ack = 0;
    end
    m_start = 0;
    m_abort = 0;
    if (wr && idx == 0 && be[1]) m_irq_en = wd[8];
    if (wr && idx == 2 && !busy_old) begin
      if (be[0]) m_pc[7:0]  = wd[7:0];
      if (be[1]) m_pc[13:8] = wd[13:8];
    end
    if (wr && idx == 1 && be[0]) begin
      if (wd[1]) m_done = 0;
      if (wd[2]) m_err  = 0;
    end
    case (m_mode)
      0: if (start_w) begin
        m_start = 1; m_cycles = 0; m_done = 0; m_err = 0; m_mode = 1;
      end
      1: begin
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        if (seq_done || seq_err) begin
          if (seq_done) m_done = 1;
          if (seq_err) begin m_err = 1; m_code = seq_err_code; end
          m_mode = 0;
        end else if (abort_w) begin
          m_abort = 1; m_mode = 2;
        end
      end
      default: begin
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        if (!seq_busy) begin m_err = 1; m_code = 8'hFF; m_mode = 0; end
      end
    endcase
    m_irq = n_irq;
  endtask

  always @(negedge clk) begin
    if (m_valid && !sreset) begin
      check("waitrequest", bus.cmd_waitrequest, bus.cmd_read & ~m_rd_ack);
      check("readdata", bus.cmd_readdata, m_rdata);
      check("seq_start", seq_start, m_start);
      check("seq_abort", seq_abort, m_abort);
      check("seq_pc", seq_pc, m_pc);
      check("irq", irq, m_irq);
    end
    model_step();
  end

  int n_start = 0;
  int n_abort = 0;
  always @(negedge clk) begin
    if (seq_start === 1'b1) n_start++;
    if (seq_abort === 1'b1) n_abort++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] idx, input logic [3:0] be, input logic [31:0] d);
    bus.cmd_address    = {18'b0, idx};
    bus.cmd_byteenable = be;
    bus.cmd_writedata  = d;
    bus.cmd_write      = 1'b1;
    tick();
    bus.cmd_write = 1'b0;
  endtask

  task automatic rd(input logic [13:0] idx, output logic [31:0] d, output int ws);
    bit got = 0;
    ws = 0;
    d  = 32'h0;
    bus.cmd_address = {18'b0, idx};
    bus.cmd_read    = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (!bus.cmd_waitrequest) begin
        d   = bus.cmd_readdata;
        got = 1;
      end else begin
        ws++;
      end
      @(posedge clk);
    end
    #1;
    bus.cmd_read = 1'b0;
    check("read_accepted", got, 1);
  endtask

  task automatic chk_rd(input string name, input logic [13:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    int          ws;
    rd(idx, d, ws);
    check(name, d, exp);
    check({name, "_waits"}, ws, 1);
  endtask

  logic [31:0] d;
  int          ws, s0, a0;
  bit          hold;

  initial begin
    sreset = 1'b1;
    bus.cmd_address = '0; bus.cmd_byteenable = '0; bus.cmd_writedata = '0;
    bus.cmd_write = 1'b0; bus.cmd_read = 1'b0;
    seq_busy = 1'b0; seq_done = 1'b0; seq_err = 1'b0; seq_err_code = 8'h00;
    repeat (3) tick();
    sreset = 1'b0;
    check("rst_readdata", bus.cmd_readdata, 32'h0);
    check("rst_wait", bus.cmd_waitrequest, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_pc", seq_pc, 14'h0);

    chk_rd("id", 14'd4, 32'hECC0_0100);
    chk_rd("unmapped", 14'd100, 32'h0);

    wr(14'd2, 4'b0001, 32'h0000_0123);
    chk_rd("pc_byte0", 14'd2, 32'h0000_0023);
    wr(14'd2, 4'b0011, 32'h0000_0123);
    check("pc_full", seq_pc, 14'h0123);

    // Normal run ending in done.
    s0 = n_start;
    wr(14'd0, 4'b0011, 32'h0000_0101);
    seq_busy = 1'b1;
    chk_rd("status_run", 14'd1, 32'h1);
    repeat (8) tick();
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0; seq_busy = 1'b0;
    check("irq_lag", irq, 1'b0);
    tick();
    check("irq_done", irq, 1'b1);
    check("start_once", n_start - s0, 1);
    chk_rd("status_done", 14'd1, 32'h2);
    rd(14'd3, d, ws);
    check("cycles_about_10", (d >= 10 && d <= 11), 1);

    // Run ending in an error.
    wr(14'd0, 4'b0001, 32'h1);
    seq_busy = 1'b1;
    repeat (3) tick();
    seq_err = 1'b1; seq_err_code = 8'h3C;
    tick();
    seq_err = 1'b0; seq_busy = 1'b0;
    tick();
    chk_rd("status_err", 14'd1, 32'h0000_3C04);
    check("irq_err", irq, 1'b1);
    wr(14'd1, 4'b0001, 32'h4);
    tick();
    check("irq_cleared", irq, 1'b0);
    chk_rd("status_w1c", 14'd1, 32'h0000_3C00);

    // Abort mid-run; sequencer drops busy three cycles later.
    s0 = n_start; a0 = n_abort;
    wr(14'd0, 4'b0001, 32'h1);
    seq_busy = 1'b1;
    repeat (2) tick();
    wr(14'd0, 4'b0001, 32'h2);
    rd(14'd1, d, ws);
    check("busy_in_abort", d[0], 1'b1);
    tick();
    seq_busy = 1'b0;
    repeat (2) tick();
    chk_rd("status_abort", 14'd1, 32'h0000_FF04);
    check("abort_once", n_abort - a0, 1);
    check("start_once_abort", n_start - s0, 1);

    a0 = n_abort;
    wr(14'd0, 4'b0001, 32'h2);
    tick();
    check("abort_in_idle", n_abort - a0, 0);

    // Done and error together.
    wr(14'd0, 4'b0001, 32'h1);
    seq_busy = 1'b1;
    tick();
    seq_done = 1'b1; seq_err = 1'b1; seq_err_code = 8'h5A;
    tick();
    seq_done = 1'b0; seq_err = 1'b0; seq_busy = 1'b0;
    chk_rd("status_both", 14'd1, 32'h0000_5A06);

    // Reset in the middle of a run.
    a0 = n_abort;
    wr(14'd0, 4'b0001, 32'h1);
    seq_busy = 1'b1;
    repeat (3) tick();
    sreset = 1'b1;
    repeat (2) tick();
    sreset = 1'b0; seq_busy = 1'b0;
    check("rst_no_abort", n_abort - a0, 0);
    check("rst_irq_run", irq, 1'b0);
    chk_rd("rst_ctrl", 14'd0, 32'h0);
    chk_rd("rst_status", 14'd1, 32'h0);
    chk_rd("rst_pc_start", 14'd2, 32'h0);
    chk_rd("rst_cycles", 14'd3, 32'h0);

    // START while busy is ignored and PC_START is locked.
    s0 = n_start;
    wr(14'd0, 4'b0001, 32'h1);
    seq_busy = 1'b1;
    tick();
    wr(14'd0, 4'b0001, 32'h1);
    wr(14'd2, 4'b0011, 32'h0000_3FFF);
    tick();
    check("start_while_busy", n_start - s0, 1);
    check("pc_locked", seq_pc, 14'h0);
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0; seq_busy = 1'b0;

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      hold = bus.cmd_read && bus.cmd_waitrequest;
      @(posedge clk);
      #1;
      seq_busy     = ($urandom_range(0, 3) != 0);
      seq_done     = ($urandom_range(0, 11) == 0);
      seq_err      = ($urandom_range(0, 15) == 0);
      seq_err_code = 8'($urandom);
      sreset       = ($urandom_range(0, 399) == 0);
      if (!hold) begin
        int r;
        bus.cmd_read  = 1'b0;
        bus.cmd_write = 1'b0;
        r = $urandom_range(0, 7);
        if ($urandom_range(0, 7) == 0) bus.cmd_address = 32'($urandom_range(5, 16383));
        else bus.cmd_address = 32'($urandom_range(0, 4));
        bus.cmd_byteenable = 4'($urandom);
        bus.cmd_writedata  = $urandom;
        if (r < 3) bus.cmd_write = 1'b1;
        else if (r < 6) bus.cmd_read = 1'b1;
      end
    end
    @(negedge clk);
    hold = bus.cmd_read && bus.cmd_waitrequest;
    @(posedge clk);
    #1;
    if (hold) tick();
    bus.cmd_read = 1'b0; bus.cmd_write = 1'b0; sreset = 1'b0;
    seq_done = 1'b0; seq_err = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
